// File: rtl/jtag_tap_ctrl.sv
// IEEE 1149.1 TAP controller: 16-state FSM, instruction register, BYPASS,
// IDCODE and one user data register with parallel capture/update.
module jtag_tap_ctrl #(
    parameter int unsigned      IR_W    = 4,
    parameter int unsigned      DR_W    = 8,
    parameter logic [31:0]      IDCODE  = 32'h1234_5677,
    parameter logic [IR_W-1:0]  INS_IDC = IR_W'(1),
    parameter logic [IR_W-1:0]  INS_USR = IR_W'(2)
) (
    input  logic             TCK,
    input  logic             TRST,
    input  logic             TMS,
    input  logic             TDI,
    output logic             TDO,
    output logic             TDO_EN,
    output logic [3:0]       state_obs,
    output logic [IR_W-1:0]  ir_q,
    input  logic [DR_W-1:0]  usr_in,
    output logic [DR_W-1:0]  usr_out,
    output logic             usr_upd
);

    localparam int unsigned ID_W = 32;

    localparam logic [3:0] S_TLR    = 4'd0;
    localparam logic [3:0] S_RTI    = 4'd1;
    localparam logic [3:0] S_SEL_DR = 4'd2;
    localparam logic [3:0] S_CAP_DR = 4'd3;
    localparam logic [3:0] S_SH_DR  = 4'd4;
    localparam logic [3:0] S_EX1_DR = 4'd5;
    localparam logic [3:0] S_PAU_DR = 4'd6;
    localparam logic [3:0] S_EX2_DR = 4'd7;
    localparam logic [3:0] S_UPD_DR = 4'd8;
    localparam logic [3:0] S_SEL_IR = 4'd9;
    localparam logic [3:0] S_CAP_IR = 4'd10;
    localparam logic [3:0] S_SH_IR  = 4'd11;
    localparam logic [3:0] S_EX1_IR = 4'd12;
    localparam logic [3:0] S_PAU_IR = 4'd13;
    localparam logic [3:0] S_EX2_IR = 4'd14;
    localparam logic [3:0] S_UPD_IR = 4'd15;

    logic [3:0]      state;
    logic [3:0]      state_nxt;
    logic [IR_W-1:0] ir_sr;
    logic [ID_W-1:0] id_sr;
    logic [DR_W-1:0] usr_sr;
    logic            byp_sr;
    logic            sel_idc;
    logic            sel_usr;

    assign state_obs = state;
    assign sel_idc   = (ir_q == INS_IDC);
    assign sel_usr   = (ir_q == INS_USR);

    always_ff @(posedge TCK or posedge TRST) begin
        if (TRST) state <= S_TLR;
        else      state <= state_nxt;
    end

    // Standard 1149.1 state graph, TMS sampled on rising TCK
    always_comb begin
        state_nxt = state;
        case (state)
            S_TLR:    state_nxt = TMS ? S_TLR    : S_RTI;
            S_RTI:    state_nxt = TMS ? S_SEL_DR : S_RTI;
            S_SEL_DR: state_nxt = TMS ? S_SEL_IR : S_CAP_DR;
            S_CAP_DR: state_nxt = TMS ? S_EX1_DR : S_SH_DR;
            S_SH_DR:  state_nxt = TMS ? S_EX1_DR : S_SH_DR;
            S_EX1_DR: state_nxt = TMS ? S_UPD_DR : S_PAU_DR;
            S_PAU_DR: state_nxt = TMS ? S_EX2_DR : S_PAU_DR;
            S_EX2_DR: state_nxt = TMS ? S_UPD_DR : S_SH_DR;
            S_UPD_DR: state_nxt = TMS ? S_SEL_DR : S_RTI;
            S_SEL_IR: state_nxt = TMS ? S_TLR    : S_CAP_IR;
            S_CAP_IR: state_nxt = TMS ? S_EX1_IR : S_SH_IR;
            S_SH_IR:  state_nxt = TMS ? S_EX1_IR : S_SH_IR;
            S_EX1_IR: state_nxt = TMS ? S_UPD_IR : S_PAU_IR;
            S_PAU_IR: state_nxt = TMS ? S_EX2_IR : S_PAU_IR;
            S_EX2_IR: state_nxt = TMS ? S_UPD_IR : S_SH_IR;
            S_UPD_IR: state_nxt = TMS ? S_SEL_DR : S_RTI;
            default:  state_nxt = S_TLR;
        endcase
    end

    // Shift registers: capture/shift on rising TCK, hold in every other state
    always_ff @(posedge TCK or posedge TRST) begin
        if (TRST) begin
            ir_sr  <= '0;
            id_sr  <= '0;
            usr_sr <= '0;
            byp_sr <= 1'b0;
        end else begin
            if (state == S_CAP_IR)
                ir_sr <= IR_W'(1);
            else if (state == S_SH_IR)
                ir_sr <= {TDI, ir_sr[IR_W-1:1]};

            if (state == S_CAP_DR) begin
                id_sr  <= IDCODE;
                usr_sr <= usr_in;
                byp_sr <= 1'b0;
            end else if (state == S_SH_DR) begin
                if (sel_idc)
                    id_sr <= {TDI, id_sr[ID_W-1:1]};
                else if (sel_usr)
                    usr_sr <= (usr_sr >> 1) | (DR_W'(TDI) << (DR_W - 1));
                else
                    byp_sr <= TDI;
            end
        end
    end

    // Falling-edge stage: updates and TDO launch, driven only by registered state
    always_ff @(negedge TCK or posedge TRST) begin
        if (TRST) begin
            ir_q    <= INS_IDC;
            usr_out <= '0;
            usr_upd <= 1'b0;
            TDO     <= 1'b0;
            TDO_EN  <= 1'b0;
        end else begin
            usr_upd <= (state == S_UPD_DR) && sel_usr;
            if ((state == S_UPD_DR) && sel_usr)
                usr_out <= usr_sr;

            // Forcing here lands before the next rising edge seen in TLR
            if (state == S_TLR)
                ir_q <= INS_IDC;
            else if (state == S_UPD_IR)
                ir_q <= ir_sr;

            case (state)
                S_SH_IR: begin
                    TDO    <= ir_sr[0];
                    TDO_EN <= 1'b1;
                end
                S_SH_DR: begin
                    TDO    <= sel_idc ? id_sr[0] : (sel_usr ? usr_sr[0] : byp_sr);
                    TDO_EN <= 1'b1;
                end
                default: begin
                    TDO    <= 1'b0;
                    TDO_EN <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Directed bench for jtag_tap_ctrl: state walk, IDCODE, bypass, user DR,
// pause/resume and TRST abort, checked against hand-computed values.
module tb_jtag_tap_ctrl;

    localparam int unsigned IR_W = 4;
    localparam int unsigned DR_W = 8;

    logic            TCK;
    logic            TRST;
    logic            TMS;
    logic            TDI;
    logic            TDO;
    logic            TDO_EN;
    logic [3:0]      state_obs;
    logic [IR_W-1:0] ir_q;
    logic [DR_W-1:0] usr_in;
    logic [DR_W-1:0] usr_out;
    logic            usr_upd;

    int checks = 0;
    int errors = 0;

    jtag_tap_ctrl #(
        .IR_W    (IR_W),
        .DR_W    (DR_W),
        .IDCODE  (32'h1234_5677),
        .INS_IDC (4'b0001),
        .INS_USR (4'b0010)
    ) dut (
        .TCK       (TCK),
        .TRST      (TRST),
        .TMS       (TMS),
        .TDI       (TDI),
        .TDO       (TDO),
        .TDO_EN    (TDO_EN),
        .state_obs (state_obs),
        .ir_q      (ir_q),
        .usr_in    (usr_in),
        .usr_out   (usr_out),
        .usr_upd   (usr_upd)
    );

    initial begin
        TCK = 1'b0;
        forever #5 TCK = ~TCK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, time=%0t", $time);
        $fatal(1, "watchdog");
    end

    // One TCK period; outputs sampled just after the falling edge
    task automatic tick(input logic tms, input logic tdi);
        TMS = tms;
        TDI = tdi;
        @(posedge TCK);
        @(negedge TCK);
        #1;
    endtask

    task automatic goto_shdr();
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
    endtask

    task automatic goto_shir();
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
    endtask

    // Shift n bits from a Shift state, leaving via Exit1 on the last bit
    task automatic shift_bits(input int n, input logic [31:0] din,
                              output logic [31:0] dout, output int en_bad);
        dout   = '0;
        en_bad = 0;
        for (int i = 0; i < n; i++) begin
            dout[i] = TDO;
            if (TDO_EN !== 1'b1) en_bad++;
            tick(i == n - 1, din[i]);
        end
    endtask

    task automatic test_reset();
        TRST   = 1'b1;
        TMS    = 1'b0;
        TDI    = 1'b0;
        usr_in = '0;
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        checks++;
        if (state_obs !== 4'd0) begin
            errors++; $display("FAIL reset_state: got %0d want 0", state_obs);
        end
        checks++;
        if (ir_q !== 4'b0001) begin
            errors++; $display("FAIL reset_ir: got %h want 1", ir_q);
        end
        checks++;
        if ({TDO, TDO_EN, usr_upd} !== 3'b000 || usr_out !== 8'h00) begin
            errors++;
            $display("FAIL reset_outs: tdo=%b en=%b upd=%b out=%h want 0", TDO, TDO_EN, usr_upd, usr_out);
        end
        TRST = 1'b0;
        tick(1'b1, 1'b0);
        checks++;
        if (state_obs !== 4'd0) begin
            errors++; $display("FAIL tlr_hold: got %0d want 0", state_obs);
        end
    endtask

    task automatic test_tlr_from_any();
        // TLR -> RTI -> SelDR -> SelIR -> CapIR -> ShIR
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        checks++;
        if (state_obs !== 4'd11 || TDO !== 1'b1 || TDO_EN !== 1'b1) begin
            errors++;
            $display("FAIL walk_shir: state=%0d tdo=%b en=%b want 11/1/1", state_obs, TDO, TDO_EN);
        end
        // TDI=1 makes UpdIR load 4'h8, then TLR must restore IDCODE opcode
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b1);
        checks++;
        if (state_obs !== 4'd0 || ir_q !== 4'b0001) begin
            errors++;
            $display("FAIL tlr_from_shir: state=%0d ir=%h want 0/1", state_obs, ir_q);
        end
        tick(1'b0, 1'b0);
        checks++;
        if (state_obs !== 4'd1) begin
            errors++; $display("FAIL tlr_to_rti: got %0d want 1", state_obs);
        end
        // RTI -> SelDR -> CapDR -> Ex1DR -> PauDR
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        checks++;
        if (state_obs !== 4'd6) begin
            errors++; $display("FAIL walk_paudr: got %0d want 6", state_obs);
        end
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b0);
        checks++;
        if (state_obs !== 4'd0) begin
            errors++; $display("FAIL tlr_from_paudr: got %0d want 0", state_obs);
        end
        tick(1'b0, 1'b0);
    endtask

    task automatic test_idcode();
        logic [31:0] dout;
        int en_bad;
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        checks++;
        if (state_obs !== 4'd3 || TDO_EN !== 1'b0) begin
            errors++; $display("FAIL cap_dr: state=%0d en=%b want 3/0", state_obs, TDO_EN);
        end
        tick(1'b0, 1'b0);
        shift_bits(32, 32'h0, dout, en_bad);
        checks++;
        if (dout !== 32'h1234_5677) begin
            errors++; $display("FAIL idcode: got %h want 12345677", dout);
        end
        checks++;
        if (en_bad != 0 || TDO_EN !== 1'b0 || state_obs !== 4'd5) begin
            errors++;
            $display("FAIL idcode_en: bad=%0d en_after=%b state=%0d want 0/0/5", en_bad, TDO_EN, state_obs);
        end
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
    endtask

    task automatic test_bypass();
        logic [31:0] dout;
        int en_bad;
        goto_shir();
        shift_bits(4, 32'hF, dout, en_bad);
        tick(1'b1, 1'b0);
        checks++;
        if (ir_q !== 4'hF) begin
            errors++; $display("FAIL ir_bypass: got %h want f", ir_q);
        end
        tick(1'b0, 1'b0);
        goto_shdr();
        // TDI sequence 1,0,1,1 -> TDO 0,1,0,1
        shift_bits(4, 32'b1101, dout, en_bad);
        checks++;
        if (dout[3:0] !== 4'b1010 || en_bad != 0) begin
            errors++; $display("FAIL bypass: got %b bad=%0d want 1010/0", dout[3:0], en_bad);
        end
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
    endtask

    task automatic test_user();
        logic [31:0] dout;
        int en_bad;
        goto_shir();
        shift_bits(4, 32'b0010, dout, en_bad);
        checks++;
        if (dout[3:0] !== 4'b0001) begin
            errors++; $display("FAIL ir_capture: got %b want 0001", dout[3:0]);
        end
        tick(1'b1, 1'b0);
        checks++;
        if (ir_q !== 4'h2) begin
            errors++; $display("FAIL ir_user: got %h want 2", ir_q);
        end
        tick(1'b0, 1'b0);
        usr_in = 8'hA5;
        goto_shdr();
        shift_bits(8, 32'h3C, dout, en_bad);
        checks++;
        if (dout[7:0] !== 8'hA5 || en_bad != 0) begin
            errors++; $display("FAIL user_tdo: got %h bad=%0d want a5/0", dout[7:0], en_bad);
        end
        checks++;
        if (usr_upd !== 1'b0 || usr_out !== 8'h00) begin
            errors++; $display("FAIL user_preupd: upd=%b out=%h want 0/00", usr_upd, usr_out);
        end
        tick(1'b1, 1'b0);
        checks++;
        if (usr_upd !== 1'b1 || usr_out !== 8'h3C) begin
            errors++; $display("FAIL user_upd: upd=%b out=%h want 1/3c", usr_upd, usr_out);
        end
        tick(1'b0, 1'b0);
        checks++;
        if (usr_upd !== 1'b0 || usr_out !== 8'h3C) begin
            errors++; $display("FAIL user_upd_end: upd=%b out=%h want 0/3c", usr_upd, usr_out);
        end
    endtask

    task automatic test_pause_resume();
        logic [31:0] d1;
        logic [31:0] d2;
        int bad1;
        int bad2;
        usr_in = 8'h5A;
        goto_shdr();
        shift_bits(3, 32'h3, d1, bad1);
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b1);
        checks++;
        if (state_obs !== 4'd6 || TDO_EN !== 1'b0) begin
            errors++; $display("FAIL pause: state=%0d en=%b want 6/0", state_obs, TDO_EN);
        end
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        shift_bits(5, 32'h18, d2, bad2);
        checks++;
        if ({d2[4:0], d1[2:0]} !== 8'h5A || bad1 != 0 || bad2 != 0) begin
            errors++;
            $display("FAIL pause_tdo: got %h bad=%0d/%0d want 5a", {d2[4:0], d1[2:0]}, bad1, bad2);
        end
        tick(1'b1, 1'b0);
        checks++;
        if (usr_out !== 8'hC3 || usr_upd !== 1'b1) begin
            errors++; $display("FAIL pause_upd: out=%h upd=%b want c3/1", usr_out, usr_upd);
        end
        tick(1'b0, 1'b0);
    endtask

    task automatic test_trst_abort();
        int upd_seen;
        usr_in = 8'hFF;
        goto_shdr();
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b1);
        TMS = 1'b1;
        @(posedge TCK);
        #2;
        TRST = 1'b1;
        #1;
        checks++;
        if (state_obs !== 4'd0 || TDO_EN !== 1'b0 || usr_out !== 8'h00 || ir_q !== 4'b0001) begin
            errors++;
            $display("FAIL trst_abort: state=%0d en=%b out=%h ir=%h want 0/0/00/1", state_obs, TDO_EN, usr_out, ir_q);
        end
        upd_seen = 0;
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 1'b0);
            if (usr_upd !== 1'b0) upd_seen++;
        end
        TRST = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b0);
            if (usr_upd !== 1'b0) upd_seen++;
        end
        checks++;
        if (upd_seen != 0 || usr_out !== 8'h00) begin
            errors++; $display("FAIL trst_noupd: pulses=%0d out=%h want 0/00", upd_seen, usr_out);
        end
        checks++;
        if (state_obs !== 4'd1) begin
            errors++; $display("FAIL trst_recover: got %0d want 1", state_obs);
        end
    endtask

    initial begin
        test_reset();
        test_tlr_from_any();
        test_idcode();
        test_bypass();
        test_user();
        test_pause_resume();
        test_trst_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
